// File: rtl/ifu_sram_fetch.sv
// Purpose: instruction fetch unit; takes a PC, reads one word from the instruction SRAM, hands it to the IDU.
// Latency: PC accepted in cycle N -> arvalid in N+1 -> inst_valid in N+3 at the earliest.
// Backpressure: one transaction in flight; pc_ready stays low until the IDU takes the word or a flush retires it.
// Build option: define IFU_MISALIGN_CHECK_EN to complete misaligned PCs locally with fetch_err=1 and no SRAM read.
module ifu_sram_fetch #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // PC stage
  input  logic             pc_valid,
  output logic             pc_ready,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             flush,
  // instruction SRAM read-address channel
  output logic             arvalid,
  input  logic             arready,
  output logic [WIDTH-1:0] araddr,
  // instruction SRAM read-data channel
  input  logic             rvalid,
  output logic             rready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  // IDU
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             fetch_err
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state;
  // set when a redirect arrives while the SRAM read is in flight; the
  // response is then drained and dropped instead of being presented
  logic   kill;
  logic   pc_misaligned;
  logic   resp_err;

  // Misalignment only matters when the local-error shortcut is built in;
  // otherwise every accepted PC goes to the SRAM untouched.
`ifdef IFU_MISALIGN_CHECK_EN
  assign pc_misaligned = (pc_in[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  assign resp_err = (rresp != RESP_OKAY);

  // Handshake strobes decode the state register only, so no input reaches
  // an output combinationally and reset takes them to IDLE values at once.
  assign pc_ready   = (state == S_IDLE);
  assign arvalid    = (state == S_ADDR);
  assign rready     = (state == S_DATA);
  assign inst_valid = (state == S_OUT);

  // Fetch sequencer: IDLE -> ADDR -> DATA -> OUT -> IDLE, with kill handling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      kill      <= 1'b0;
      araddr    <= '0;
      inst_pc   <= '0;
      inst      <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // a redirect in the same cycle wins over the offered PC
          if (pc_valid && !flush) begin
            araddr  <= pc_in;
            inst_pc <= pc_in;
            kill    <= 1'b0;
            if (pc_misaligned) begin
              inst      <= '0;
              fetch_err <= 1'b1;
              state     <= S_OUT;
            end else begin
              state <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
          // the address must stay offered until taken, so a flush only
          // marks the transaction as dead
          if (flush) begin
            kill <= 1'b1;
          end
          if (arready) begin
            state <= S_DATA;
          end
        end

        S_DATA: begin
          if (flush) begin
            kill <= 1'b1;
          end
          if (rvalid) begin
            if (kill || flush) begin
              // response consumed and thrown away
              kill  <= 1'b0;
              state <= S_IDLE;
            end else begin
              // an error response never leaks bus data to the decoder
              inst      <= resp_err ? 32'h0000_0000 : rdata;
              fetch_err <= resp_err;
              state     <= S_OUT;
            end
          end
        end

        S_OUT: begin
          if (inst_ready || flush) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Protocol invariants of the four channels
  a_one_phase: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot({pc_ready, arvalid, rready, inst_valid}));

  a_ar_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)));

  a_inst_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (inst_valid && !inst_ready && !flush) |=>
      (inst_valid && $stable(inst) && $stable(inst_pc) && $stable(fetch_err)));

  a_err_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (inst_valid && fetch_err) |-> (inst == 32'h0000_0000));

endmodule
